// File: rtl/ah_pkt_router_pkg.sv
// Shared types and helpers for the packet router: FSM state encoding,
// default client count and the one-hot select check.
package ah_router_pkg;

  localparam int NUM_CLIENTS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } router_state_e;

  // Callers zero-extend their select to 32 bits, so any client count up to 32 works.
  function automatic logic onehot_ok(input logic [31:0] sel);
    return (sel != 32'd0) && ((sel & (sel - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/ah_pkt_router_if.sv
// Ingress beat stream (with decoder sideband) and per-client egress stream.
// valid/ready: a beat transfers on a cycle where valid & ready are both high; once valid rises, the payload holds until that transfer happens.
interface ah_pkt_router_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   in_sop;
  logic                   in_eop;
  logic [NUM_CLIENTS-1:0] dec_sel;
  logic                   dec_err;

  logic [NUM_CLIENTS-1:0] out_valid;
  logic [NUM_CLIENTS-1:0] out_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_sop;
  logic                   out_eop;

  modport master (
    output in_valid, in_data, in_sop, in_eop, dec_sel, dec_err, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, dec_sel, dec_err, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/ah_pkt_router_out_buf.sv
// Single-entry register slice holding one routed beat and its client select.
module ah_pkt_out_buf #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   push_sop,
  input  logic                   push_eop,
  input  logic [NUM_CLIENTS-1:0] push_sel,
  input  logic [NUM_CLIENTS-1:0] out_ready,
  output logic                   buf_valid,
  output logic                   drain,
  output logic [NUM_CLIENTS-1:0] out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sop,
  output logic                   out_eop
);

  logic [NUM_CLIENTS-1:0] sel_q;

  // Push wins over drain so a same-cycle drain and load leaves no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      sel_q     <= '0;
    end else if (push) begin
      buf_valid <= 1'b1;
      out_data  <= push_data;
      out_sop   <= push_sop;
      out_eop   <= push_eop;
      sel_q     <= push_sel;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  assign out_valid = buf_valid ? sel_q : '0;
  assign drain     = |(out_valid & out_ready);

endmodule

// File: rtl/ah_pkt_router.sv
// Locks a client route on start-of-packet, forwards the packet through a
// registered output slice, and drops packets that miss decode.
module ah_pkt_router
  import ah_router_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int DATA_W      = 32,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ah_pkt_router_if.slave       bus,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output router_state_e        state
);

  router_state_e          state_q, state_d;
  logic [NUM_CLIENTS-1:0] sel_q;
  logic                   buf_valid, drain;
  logic                   in_ready_c, acc, bad;
  logic                   push, push_sop, err_evt, load_sel;
  logic [NUM_CLIENTS-1:0] push_sel;

  assign bad = bus.dec_err | !onehot_ok(32'(bus.dec_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc && bus.in_sop && !bus.in_eop) state_d = bad ? DROP : FWD;
      FWD:  if (acc && bus.in_eop) state_d = IDLE;
      DROP: if (acc && bus.in_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = (state_q == DROP) | !buf_valid | drain;
    acc        = bus.in_valid & in_ready_c;
    push       = 1'b0;
    push_sel   = sel_q;
    push_sop   = 1'b0;
    err_evt    = 1'b0;
    load_sel   = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (!bus.in_sop || bad) begin
          err_evt = 1'b1;
        end else begin
          push     = 1'b1;
          push_sel = bus.dec_sel;
          push_sop = 1'b1;
          load_sel = 1'b1;
        end
      end
      // A stray sop inside a packet travels on as plain data.
      FWD: if (acc) begin
        push    = 1'b1;
        err_evt = bus.in_sop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sel_q <= '0;
    else if (load_sel) sel_q <= bus.dec_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_evt;
      if (err_evt && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  ah_pkt_out_buf #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .DATA_W     (DATA_W)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(bus.in_data),
    .push_sop (push_sop),
    .push_eop (bus.in_eop),
    .push_sel (push_sel),
    .out_ready(bus.out_ready),
    .buf_valid(buf_valid),
    .drain    (drain),
    .out_valid(bus.out_valid),
    .out_data (bus.out_data),
    .out_sop  (bus.out_sop),
    .out_eop  (bus.out_eop)
  );

  assign bus.in_ready = in_ready_c;
  assign state        = state_q;

endmodule

// File: doc/ah_pkt_router.md
Name: ah_pkt_router

Overview:
- Sits directly downstream of the address decoder stage.
- Takes ingress packet beats together with the decoder's one-hot client select and decode-error flag, both valid on the start-of-packet beat.
- Locks a route on start-of-packet, forwards every beat of the packet to the selected client over a valid/ready interface, and discards packets that miss decode.
- Registered output stage; reports errors via a pulse and a saturating counter.

Parameters:
- NUM_CLIENTS, 4, number of egress clients; width of the decoder select.
- DATA_W, 32, packet beat data width.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  ingress beat valid.
- in_ready  output  1  ingress beat accepted when in_valid & in_ready.
- in_data  input  DATA_W  ingress beat payload.
- in_sop  input  1  first beat of packet.
- in_eop  input  1  last beat of packet.
- dec_sel  input  NUM_CLIENTS  one-hot client select from decoder; sampled only on the accepted sop beat.
- dec_err  input  1  decoder miss; sampled only on the accepted sop beat.
- out_valid  output  NUM_CLIENTS  per-client beat valid; at most one bit set.
- out_ready  input  NUM_CLIENTS  per-client ready.
- out_data  output  DATA_W  egress payload, shared by all clients.
- out_sop  output  1  egress first-beat flag.
- out_eop  output  1  egress last-beat flag.
- err_pulse  output  1  one-cycle pulse per error event.
- err_count  output  ERR_CNT_W  saturating count of error events.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sop=0, out_eop=0, err_pulse=0, err_count=0, state=IDLE, locked select=0. in_ready=1 in IDLE after reset.
- Reset asserted mid-packet aborts the packet. The output buffer is cleared and the remainder of the packet is not delivered.
- Effective miss: bad = dec_err | (dec_sel not exactly one-hot, including all-zero).
- State machine:
  - IDLE: waiting for sop.
  - FWD: route locked to sel_q.
  - DROP: discarding the current packet.
- IDLE transitions:
  - Accepted beat with in_sop & !bad: load sel_q=dec_sel and push the beat to the output buffer. If in_eop is also set, stay in IDLE (single-beat packet); else go to FWD.
  - Accepted beat with in_sop & bad: pulse err_pulse and increment err_count. If in_eop is also set, stay in IDLE; else go to DROP. Nothing is emitted.
  - Accepted beat without in_sop (framing error): discard, pulse err_pulse, increment err_count, stay in IDLE.
- FWD transitions:
  - Every accepted beat is pushed to the output buffer with sel_q.
  - An accepted beat with in_eop returns to IDLE.
  - in_sop seen in FWD (framing error): the beat is forwarded as data with out_sop forced to 0, and an error is counted.
- DROP transitions:
  - in_ready=1 unconditionally.
  - Beats are discarded without counting further errors.
  - An accepted beat with in_eop returns to IDLE.
- Output buffer: single register stage, so a beat appears on the outputs 1 cycle after acceptance.
  - out_valid = buf_valid ? buf_sel : 0.
  - The buffer drains when (out_valid & out_ready) != 0.
- in_ready:
  - In IDLE and FWD: in_ready = !buf_valid | drain. This allows full throughput of 1 beat/cycle when the client holds ready high.
  - In IDLE the buffer may still hold the previous packet's last beat. A new sop may load a different select in the same cycle that beat drains; the buffer then carries the new beat with its own select.
- Output stability: while out_valid is set and the client is not ready, out_data, out_sop, out_eop and the select stay stable.
- err_count saturates at all-ones; further errors still pulse err_pulse.
- Simultaneous events:
  - Drain and load in the same cycle → the new beat replaces the old one with no bubble.
  - At most one error increment per cycle.

Decomposition:
- Shared package ah_router_pkg holds:
  - the state enum (IDLE, FWD, DROP);
  - the NUM_CLIENTS default;
  - the function onehot_ok(sel), which returns 1 when exactly one bit is set.
- One sub-module, ah_pkt_out_buf: the single-entry valid/ready register slice carrying data, sop, eop and sel.

Test Plan:
1. Single-beat packet: sop=eop=1, dec_sel=4'b0100, dec_err=0, data=0xA5A5A5A5, out_ready=4'hF → next cycle out_valid=4'b0100, out_data=0xA5A5A5A5, out_sop=out_eop=1; err_count stays 0.
2. 4-beat packet to client 1 with out_ready[1] low for 3 cycles mid-packet → in_ready drops, out_data is held stable, all 4 beats arrive in order, and state returns to IDLE after eop.
3. Decode miss: sop with dec_err=1, followed by 3 beats ending in eop → out_valid stays 0, err_pulse is high for exactly 1 cycle, err_count=1, in_ready stays 1 throughout.
4. Multi-hot dec_sel=4'b0011 with dec_err=0 → treated as a miss: packet dropped, err_count increments.
5. Back-to-back packets to clients 0 then 3 with out_ready all high → 1 beat/cycle with no bubble; the last beat of packet A goes to out_valid=4'b0001 and the next cycle carries out_valid=4'b1000 with sop.
6. rst_n pulsed low in the middle of a FWD packet → all outputs return to 0 asynchronously; after release, a non-sop beat is discarded as a framing error (err_count=1), and the next sop routes normally.
